// File: rtl/logic_blocks_pkg.sv
// Shared constants and helpers for the RV32I logic-block cells (and/or/xor).
package logic_blocks_pkg;

   localparam int LB_WIDTH_DEF     = 1;
   localparam int LB_CNT_WIDTH_DEF = 16;

   // Widest counter sat_inc serves; callers zero-extend into it and truncate the result back.
   localparam int LB_SAT_W = 32;

   function automatic logic [LB_SAT_W-1:0] sat_inc(input logic [LB_SAT_W-1:0] value,
                                                   input logic [LB_SAT_W-1:0] max_value);
      return (value >= max_value) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/and_gate_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over increment) and async active-low reset.
module and_gate_sat_cnt
   import logic_blocks_pkg::*;
#(
   parameter int WIDTH = LB_CNT_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] cnt
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt;
      if (clr) begin
         cnt_next = '0;
      end else if (inc) begin
         cnt_next = WIDTH'(sat_inc(LB_SAT_W'(cnt), LB_SAT_W'(CNT_MAX)));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_next;
      end
   end

endmodule

// File: rtl/and_gate.sv
// Bitwise AND cell with registered copy, all-ones flag and optional saturating hit counter.
// Define AND_GATE_STATS_EN to build the hit counter; otherwise hit_cnt is tied to 0.
module and_gate
   import logic_blocks_pkg::*;
#(
   parameter int WIDTH     = LB_WIDTH_DEF,
   parameter int CNT_WIDTH = LB_CNT_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [WIDTH-1:0]     c,
   output logic [WIDTH-1:0]     c_q,
   output logic                 c_all,
   input  logic                 cnt_clr,
   output logic [CNT_WIDTH-1:0] hit_cnt
);

   logic c_all_next;

   assign c          = a & b;
   assign c_all_next = &(a & b);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_q   <= '0;
         c_all <= 1'b0;
      end else begin
         c_q   <= a & b;
         c_all <= c_all_next;
      end
   end

`ifdef AND_GATE_STATS_EN
   and_gate_sat_cnt #(
      .WIDTH (CNT_WIDTH)
   ) u_sat_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (c_all_next),
      .clr   (cnt_clr),
      .cnt   (hit_cnt)
   );
`else
   // cnt_clr has no consumer in this build; the name keeps it out of unused-signal reports.
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign hit_cnt        = '0;
`endif

endmodule

// File: tb/tb_and_gate.sv
// Self-checking bench for and_gate: WIDTH=8/CNT_WIDTH=2 and WIDTH=1 instances against a behavioural model.
module tb_and_gate;

   localparam int W8      = 8;
   localparam int CW8     = 2;
   localparam int CNT_MAX = (1 << CW8) - 1;

   logic            clk;
   logic            rst_n;
   logic            cnt_clr;
   logic [W8-1:0]   a8, b8, c8, c_q8;
   logic            c_all8;
   logic [CW8-1:0]  hit_cnt8;
   logic            a1, b1, c1, c_q1, c_all1;
   logic [15:0]     hit_cnt1;

   int compared   = 0;
   int mismatched = 0;
   bit check_en   = 0;

   // Behavioural model state
   logic [W8-1:0] m_q    = '0;
   bit            m_all  = 0;
   int            m_cnt  = 0;
   logic          m1_q   = 1'b0;

   and_gate #(.WIDTH(W8), .CNT_WIDTH(CW8)) dut8 (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a8),
      .b       (b8),
      .c       (c8),
      .c_q     (c_q8),
      .c_all   (c_all8),
      .cnt_clr (cnt_clr),
      .hit_cnt (hit_cnt8)
   );

   and_gate dut1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a1),
      .b       (b1),
      .c       (c1),
      .c_q     (c_q1),
      .c_all   (c_all1),
      .cnt_clr (cnt_clr),
      .hit_cnt (hit_cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: registered AND, all-ones flag, saturating counter with clear priority (stats build only).
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q   = '0;
         m_all = 0;
         m_cnt = 0;
         m1_q  = 1'b0;
      end else begin
         m_q   = a8 & b8;
         m_all = ((a8 & b8) == 8'hFF);
         m1_q  = a1 & b1;
`ifdef AND_GATE_STATS_EN
         if (cnt_clr)
            m_cnt = 0;
         else if (m_all)
            m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
`endif
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [W8-1:0] a_v, input logic [W8-1:0] b_v, input logic clr_v);
      a8      = a_v;
      b8      = b_v;
      a1      = a_v[0];
      b1      = b_v[0];
      cnt_clr = clr_v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulseReset();
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
   endtask

   // Per-cycle comparison against the model, half a period after each active edge.
   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("c8",       32'(c8),       32'(a8 & b8));
         checkOutput("c_q8",     32'(c_q8),     32'(m_q));
         checkOutput("c_all8",   32'(c_all8),   32'(m_all));
         checkOutput("hit_cnt8", 32'(hit_cnt8), 32'(m_cnt));
         checkOutput("c1",       32'(c1),       32'(a1 & b1));
         checkOutput("c_q1",     32'(c_q1),     32'(m1_q));
         checkOutput("c_all1",   32'(c_all1),   32'(m1_q));
      end
   end

   initial begin
      logic [3:0] tt_exp;
      int         hit_exp [5];
      rst_n = 1'b0;
      applyStimulus(8'h00, 8'h00, 1'b0);
      tt_exp = 4'b1000;
`ifdef AND_GATE_STATS_EN
      hit_exp = '{1, 2, 3, 3, 3};
`else
      hit_exp = '{0, 0, 0, 0, 0};
`endif

      // Truth table on the WIDTH=1 cell, held in reset to show c ignores clk/rst_n
      for (int i = 0; i < 4; i++) begin
         a1 = i[1];
         b1 = i[0];
         #10;
         checkOutput("tt_c1", 32'(c1), 32'(tt_exp[i]));
      end
      checkOutput("rst_c_q8",    32'(c_q8),     32'h0);
      checkOutput("rst_c_all8",  32'(c_all8),   32'h0);
      checkOutput("rst_hit8",    32'(hit_cnt8), 32'h0);

      @(negedge clk);
      rst_n = 1'b1;
      check_en = 1;

      applyStimulus(8'hF0, 8'h3C, 1'b0);
      #1 checkOutput("f0_3c_c", 32'(c8), 32'h30);
      tick();
      checkOutput("f0_3c_c_q",   32'(c_q8),   32'h30);
      checkOutput("f0_3c_c_all", 32'(c_all8), 32'h0);

      applyStimulus(8'hFF, 8'hFF, 1'b0);
      tick();
      checkOutput("ff_c_all", 32'(c_all8), 32'h1);
      applyStimulus(8'hFE, 8'hFF, 1'b0);
      tick();
      checkOutput("fe_c_all", 32'(c_all8), 32'h0);

      // Async reset between edges with c_q holding a value
      applyStimulus(8'hFF, 8'hFF, 1'b0);
      tick();
      #2 rst_n = 1'b0;
      #1;
      checkOutput("arst_c_q8", 32'(c_q8),     32'h0);
      checkOutput("arst_hit8", 32'(hit_cnt8), 32'h0);
      checkOutput("arst_c_q1", 32'(c_q1),     32'h0);
      checkOutput("arst_c8",   32'(c8),       32'hFF);
      #1 rst_n = 1'b1;

      // Saturation then clear-over-hit
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput($sformatf("hit_seq%0d", i), 32'(hit_cnt8), 32'(hit_exp[i]));
      end
      applyStimulus(8'hFF, 8'hFF, 1'b1);
      tick();
      checkOutput("clr_over_hit", 32'(hit_cnt8), 32'h0);

      // Randomised phase, biased toward all-ones hits, with sparse clears and reset pulses
      for (int i = 0; i < 300; i++) begin
         logic [W8-1:0] ra, rb;
         ra = ($urandom_range(0, 2) == 0) ? 8'hFF : W8'($urandom);
         rb = ($urandom_range(0, 2) == 0) ? 8'hFF : W8'($urandom);
         applyStimulus(ra, rb, ($urandom_range(0, 15) == 0));
         if ($urandom_range(0, 40) == 0)
            pulseReset();
         tick();
      end

      check_en = 0;
      #10;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
